// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared state encoding and default parameters for the multi-port register file
package reg_file_pkg;
  typedef enum logic {CLEAR, RUN} state_t;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int NR_RD_DEF = 2;
  localparam int BYPASS_DEF = 1;
  localparam int ZERO_REG_DEF = 1;
endpackage

// File: rtl/reg_file_clr_seq.sv
// reg_file_clr_seq: walks every index once after reset to zero the array, then raises ready
module reg_file_clr_seq
  import reg_file_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  clearing,
  output logic [ADDR_WIDTH-1:0] clr_cnt,
  output logic                  ready
);
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] cnt_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nx;
      clr_cnt <= cnt_nx;
    end
  end
  // the counter wraps to 0 on the same edge that leaves CLEAR
  always_comb begin
    state_nx = (state == CLEAR && clr_cnt == '1) ? RUN : state;
    cnt_nx   = (state == CLEAR) ? clr_cnt + 1'b1 : clr_cnt;
    clearing = (state == CLEAR);
    ready    = (state == RUN);
  end
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: register file with one write port, NR_RD combinational read ports,
// optional same-cycle write forwarding and optional hardwired-zero index 0
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NR_RD      = NR_RD_DEF,
  parameter int BYPASS     = BYPASS_DEF,
  parameter int ZERO_REG   = ZERO_REG_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wen,
  input  logic [ADDR_WIDTH-1:0]       waddr,
  input  logic [DATA_WIDTH-1:0]       wdata,
  input  logic [NR_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NR_RD*DATA_WIDTH-1:0] rdata,
  output logic                        ready
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] rf [DEPTH];
  logic                  clearing, run_we, we;
  logic [ADDR_WIDTH-1:0] clr_cnt, wa;
  logic [DATA_WIDTH-1:0] wd;
  reg_file_clr_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_clr_seq (
    .clk      (clk),
    .rst      (rst),
    .clearing (clearing),
    .clr_cnt  (clr_cnt),
    .ready    (ready)
  );
  // a user write that actually lands: enabled and not aimed at a hardwired zero
  always_comb begin
    run_we = wen && !(ZERO_REG != 0 && waddr == '0);
    wa     = clearing ? clr_cnt : waddr;
    wd     = clearing ? '0 : wdata;
    we     = !rst && (clearing || (ready && run_we));
  end
  always_ff @(posedge clk) begin
    if (we) rf[wa] <= wd;
  end
  for (genvar k = 0; k < NR_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    assign ra = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign rdata[k*DATA_WIDTH +: DATA_WIDTH] =
      (rst || !ready || (ZERO_REG != 0 && ra == '0)) ? '0 :
      (BYPASS != 0 && run_we && ra == waddr)         ? wdata : rf[ra];
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: random and directed checks of reg_file_mp (forwarding and non-forwarding builds) against an array model
module tb_reg_file_mp;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int DEPTH = 32;
  logic clk = 0;
  logic rst = 1;
  logic wen = 0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic [NR*AW-1:0] raddr = '0;
  logic [NR*DW-1:0] rdata, rdata_nb;
  logic ready, ready_nb;
  logic [DW-1:0] mem [DEPTH];
  int busy = -1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  reg_file_mp dut (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .ready(ready)
  );
  reg_file_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_nb), .ready(ready_nb)
  );
  function automatic logic [DW-1:0] rd(logic [NR*DW-1:0] v, int k);
    return v[k*DW +: DW];
  endfunction
  // expected read: zero while reset/clearing or at index 0, else array with optional forwarding
  function automatic logic [DW-1:0] exp_rd(int k, bit byp);
    logic [AW-1:0] a;
    a = raddr[k*AW +: AW];
    if (rst || busy != 0 || a == 0) return '0;
    if (byp && wen && a == waddr) return wdata;
    return mem[a];
  endfunction
  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    if (busy >= 0) begin
      chk("ready", 32'(ready), 32'(busy == 0));
      chk("ready_nb", 32'(ready_nb), 32'(busy == 0));
      for (int k = 0; k < NR; k++) begin
        chk($sformatf("rdata%0d", k), rd(rdata, k), exp_rd(k, 1'b1));
        chk($sformatf("rdata_nb%0d", k), rd(rdata_nb, k), exp_rd(k, 1'b0));
      end
    end
    @(posedge clk);
    if (rst) begin
      busy = DEPTH;
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end else if (busy > 0) busy--;
    else if (busy == 0 && wen && waddr != 0) mem[waddr] = wdata;
    #1;
  endtask
  task automatic set_rd(logic [AW-1:0] a0, logic [AW-1:0] a1);
    raddr = {a1, a0};
  endtask
  initial begin
    rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < DEPTH; i++) begin
      #1 chk("clr_ready_low", 32'(ready), 32'd0);
      tick();
    end
    #1 chk("ready_cycle33", 32'(ready), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      set_rd(AW'(i), AW'(DEPTH - 1 - i));
      #1 chk("init_zero", rd(rdata, 0), 32'd0);
      tick();
    end
    wen = 1; waddr = 5; wdata = 32'hDEADBEEF; set_rd(5, 1);
    #1 chk("bypass_new", rd(rdata, 0), 32'hDEADBEEF);
    chk("nobypass_old", rd(rdata_nb, 0), 32'd0);
    tick();
    wen = 0;
    #1 chk("nobypass_next", rd(rdata_nb, 0), 32'hDEADBEEF);
    tick();
    wen = 1; waddr = 0; wdata = 32'h12345678; set_rd(0, 0);
    #1 chk("zero_same0", rd(rdata, 0), 32'd0);
    chk("zero_same1", rd(rdata, 1), 32'd0);
    tick();
    wen = 0;
    #1 chk("zero_after0", rd(rdata, 0), 32'd0);
    chk("zero_after1", rd(rdata_nb, 1), 32'd0);
    tick();
    wen = 1; waddr = 7; wdata = 32'hA5A5A5A5; set_rd(7, 7);
    #1 chk("dual_port0", rd(rdata, 0), 32'hA5A5A5A5);
    chk("dual_port1", rd(rdata, 1), 32'hA5A5A5A5);
    tick();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      wen = $urandom_range(0, 1);
      waddr = AW'($urandom_range(0, DEPTH - 1));
      wdata = $urandom;
      raddr = NR * AW'($urandom);
      raddr = $urandom;
      if ($urandom_range(0, 2) == 0) raddr[AW-1:0] = waddr;
      if ($urandom_range(0, 3) == 0) raddr[2*AW-1:AW] = waddr;
      tick();
    end
    rst = 0; wen = 0;
    for (int n = 0; n < 40 && busy != 0; n++) tick();
    for (int i = 1; i < DEPTH; i++) begin
      wen = 1; waddr = AW'(i); wdata = DW'(i);
      tick();
    end
    wen = 0; set_rd(20, 31);
    #1 chk("fill_20", rd(rdata, 0), 32'd20);
    chk("fill_31", rd(rdata, 1), 32'd31);
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1; tick(); rst = 0;
    wen = 1; waddr = 3; wdata = 32'hFFFFFFFF;
    for (int i = 0; i < DEPTH; i++) begin
      #1 chk("restart_ready_low", 32'(ready), 32'd0);
      tick();
    end
    wen = 0;
    #1 chk("restart_ready", 32'(ready), 32'd1);
    set_rd(3, 3);
    #1 chk("clr_wen_idx3", rd(rdata, 0), 32'd0);
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      set_rd(AW'(i), AW'(i));
      #1 chk("restart_zero", rd(rdata, 1), 32'd0);
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
